// File: rtl/sc_display_scan_if.sv
// Display-scan port bundle: bus value and freeze control in, 7-segment drive out.
// Latency: n/a (wires only).
// Backpressure: none; the producer drives the bus freely, the scanner samples it once per frame.
//
// Signals:
//   SC_DISPLAYSCAN_DataBUS_In      value to display (8 hex nibbles)
//   SC_DISPLAYSCAN_Freeze_InLow    0 = skip the next capture, keep showing the old value
//   SC_DISPLAYSCAN_Segments_OutLow {g,f,e,d,c,b,a}, active-low
//   SC_DISPLAYSCAN_Anodes_OutLow   one-hot active-low digit enable, bit i = nibble i
//   SC_DISPLAYSCAN_DigitIndex_Out  digit currently scanned
//   SC_DISPLAYSCAN_Update_Out      one-cycle pulse when the captured value changed
interface sc_display_scan_if #(
  parameter int DATAWIDTH_BUS = 32
);
  logic [DATAWIDTH_BUS-1:0] SC_DISPLAYSCAN_DataBUS_In;
  logic                     SC_DISPLAYSCAN_Freeze_InLow;
  logic [6:0]               SC_DISPLAYSCAN_Segments_OutLow;
  logic [7:0]               SC_DISPLAYSCAN_Anodes_OutLow;
  logic [2:0]               SC_DISPLAYSCAN_DigitIndex_Out;
  logic                     SC_DISPLAYSCAN_Update_Out;

  // Producer side: drives the value, observes the display.
  modport master (
    output SC_DISPLAYSCAN_DataBUS_In,
    output SC_DISPLAYSCAN_Freeze_InLow,
    input  SC_DISPLAYSCAN_Segments_OutLow,
    input  SC_DISPLAYSCAN_Anodes_OutLow,
    input  SC_DISPLAYSCAN_DigitIndex_Out,
    input  SC_DISPLAYSCAN_Update_Out
  );

  // Scanner side.
  modport slave (
    input  SC_DISPLAYSCAN_DataBUS_In,
    input  SC_DISPLAYSCAN_Freeze_InLow,
    output SC_DISPLAYSCAN_Segments_OutLow,
    output SC_DISPLAYSCAN_Anodes_OutLow,
    output SC_DISPLAYSCAN_DigitIndex_Out,
    output SC_DISPLAYSCAN_Update_Out
  );
endinterface

// File: rtl/sc_display_scan.sv
// Eight-digit multiplexed hex display scanner; captures the bus once per frame.
// Latency: one registered cycle from state/index/capture to the pins.
// Backpressure: none; free-running prescaler, bus is only sampled in the LOAD cycle.
//
// Ports:
//   SC_DISPLAYSCAN_CLOCK_50     system clock
//   SC_DISPLAYSCAN_Reset_InLow  asynchronous active-low reset
//   disp                        display bundle (slave): bus/freeze in, segments/anodes/index/update out
module sc_display_scan #(
  parameter int DATAWIDTH_BUS       = 32,
  parameter int DATAWIDTH_PRESCALER = 16,
  parameter int PRESCALER_MAX       = 49999,
  parameter bit LEADING_ZERO_BLANK  = 1'b1
) (
  input  logic             SC_DISPLAYSCAN_CLOCK_50,
  input  logic             SC_DISPLAYSCAN_Reset_InLow,
  sc_display_scan_if.slave disp
);

  localparam logic [DATAWIDTH_PRESCALER-1:0] PRESC_MAX = DATAWIDTH_PRESCALER'(PRESCALER_MAX);

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SCAN  = 2'd2
  } state_e;

  state_e                         state_q, state_d;
  logic [DATAWIDTH_PRESCALER-1:0] presc_q, presc_d;
  logic [2:0]                     idx_q, idx_d;
  logic [DATAWIDTH_BUS-1:0]       cap_q, cap_d;
  logic [7:0]                     anodes_q, anodes_d;
  logic [6:0]                     seg_q, seg_d;
  logic [2:0]                     digidx_q, digidx_d;
  logic                           upd_q, upd_d;

  logic       tick;
  logic [3:0] nib;
  logic       lz_blank;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign tick = (presc_q == PRESC_MAX);
  assign nib  = cap_q[4*idx_q +: 4];
  // A digit is a leading zero when it and every more-significant nibble are zero;
  // digit 0 is always shown so a zero value still reads "0".
  assign lz_blank = LEADING_ZERO_BLANK && (idx_q != 3'd0) &&
                    ((cap_q >> (4*idx_q)) == '0);

  always_comb begin
    state_d  = state_q;
    presc_d  = tick ? '0 : presc_q + DATAWIDTH_PRESCALER'(1);
    idx_d    = idx_q;
    cap_d    = cap_q;
    anodes_d = 8'hFF;
    seg_d    = 7'h7F;
    digidx_d = idx_q;
    upd_d    = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (tick) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // Anodes stay dark this cycle so the previous digit never ghosts into the new frame.
        idx_d = 3'd0;
        if (disp.SC_DISPLAYSCAN_Freeze_InLow) begin
          cap_d = disp.SC_DISPLAYSCAN_DataBUS_In;
          upd_d = (disp.SC_DISPLAYSCAN_DataBUS_In != cap_q);
        end
        state_d = ST_SCAN;
      end
      ST_SCAN: begin
        anodes_d = ~(8'd1 << idx_q);
        seg_d    = lz_blank ? 7'h7F : hex7(nib);
        if (tick) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = ST_LOAD;
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  always_ff @(posedge SC_DISPLAYSCAN_CLOCK_50 or negedge SC_DISPLAYSCAN_Reset_InLow) begin
    if (!SC_DISPLAYSCAN_Reset_InLow) begin
      state_q  <= ST_BLANK;
      presc_q  <= '0;
      idx_q    <= 3'd0;
      cap_q    <= '0;
      anodes_q <= 8'hFF;
      seg_q    <= 7'h7F;
      digidx_q <= 3'd0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      cap_q    <= cap_d;
      anodes_q <= anodes_d;
      seg_q    <= seg_d;
      digidx_q <= digidx_d;
      upd_q    <= upd_d;
    end
  end

  assign disp.SC_DISPLAYSCAN_Anodes_OutLow   = anodes_q;
  assign disp.SC_DISPLAYSCAN_Segments_OutLow = seg_q;
  assign disp.SC_DISPLAYSCAN_DigitIndex_Out  = digidx_q;
  assign disp.SC_DISPLAYSCAN_Update_Out      = upd_q;

endmodule

// File: tb/tb_sc_display_scan.sv
module tb_sc_display_scan;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] bus   = 32'h0;
  logic        frz   = 1'b1;

  always #5 clk = ~clk;

  sc_display_scan_if if_a ();
  sc_display_scan_if if_b ();

  assign if_a.SC_DISPLAYSCAN_DataBUS_In   = bus;
  assign if_a.SC_DISPLAYSCAN_Freeze_InLow = frz;
  assign if_b.SC_DISPLAYSCAN_DataBUS_In   = bus;
  assign if_b.SC_DISPLAYSCAN_Freeze_InLow = frz;

  // a: leading-zero blanking on; b: all digits shown.
  sc_display_scan #(.PRESCALER_MAX(3), .LEADING_ZERO_BLANK(1'b1)) u_dut_a (
    .SC_DISPLAYSCAN_CLOCK_50   (clk),
    .SC_DISPLAYSCAN_Reset_InLow(rst_n),
    .disp                      (if_a)
  );

  sc_display_scan #(.PRESCALER_MAX(3), .LEADING_ZERO_BLANK(1'b0)) u_dut_b (
    .SC_DISPLAYSCAN_CLOCK_50   (clk),
    .SC_DISPLAYSCAN_Reset_InLow(rst_n),
    .disp                      (if_b)
  );

  typedef struct {
    logic [31:0]     bus;
    logic            frz;
    logic [31:0]     mid_bus;   // applied while digit 3 is on
    logic            exp_upd;
    logic [7:0][6:0] seg_a;     // index = digit
    logic [7:0][6:0] seg_b;
  } vec_t;

  vec_t vecs[11];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic [31:0] b, input logic f, input logic [31:0] m,
                              input logic u, input logic [55:0] sa, input logic [55:0] sb);
    vec_t v;
    v.bus = b; v.frz = f; v.mid_bus = m; v.exp_upd = u; v.seg_a = sa; v.seg_b = sb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, " anodes"}, 32'(if_a.SC_DISPLAYSCAN_Anodes_OutLow), 32'hFF);
    chk({tag, " seg_a"},  32'(if_a.SC_DISPLAYSCAN_Segments_OutLow), 32'h7F);
    chk({tag, " seg_b"},  32'(if_b.SC_DISPLAYSCAN_Segments_OutLow), 32'h7F);
    chk({tag, " index"},  32'(if_a.SC_DISPLAYSCAN_DigitIndex_Out), 32'h0);
    chk({tag, " update"}, 32'(if_a.SC_DISPLAYSCAN_Update_Out), 32'h0);
  endtask

  // Entered at the negedge inside a LOAD cycle. j=1 is the anti-ghost blank,
  // then digit d is visible for j in 4d+1..4d+4 (digit 0 only j=2..4).
  task automatic run_frame(input int fi, input vec_t v, input int last_j);
    int d;
    string t;
    bus = v.bus;
    frz = v.frz;
    for (int j = 1; j <= last_j; j++) begin
      step();
      t = $sformatf("f%0d j%0d", fi, j);
      if (j == 1) begin
        chk({t, " anodes"}, 32'(if_a.SC_DISPLAYSCAN_Anodes_OutLow), 32'hFF);
        chk({t, " seg_a"},  32'(if_a.SC_DISPLAYSCAN_Segments_OutLow), 32'h7F);
        chk({t, " index"},  32'(if_a.SC_DISPLAYSCAN_DigitIndex_Out), 32'h0);
        chk({t, " update"}, 32'(if_a.SC_DISPLAYSCAN_Update_Out), 32'(v.exp_upd));
        chk({t, " update_b"}, 32'(if_b.SC_DISPLAYSCAN_Update_Out), 32'(v.exp_upd));
      end else begin
        d = (j - 1) / 4;
        chk({t, " anodes"}, 32'(if_a.SC_DISPLAYSCAN_Anodes_OutLow), 32'(8'(~(8'd1 << d))));
        chk({t, " anodes_b"}, 32'(if_b.SC_DISPLAYSCAN_Anodes_OutLow), 32'(8'(~(8'd1 << d))));
        chk({t, " seg_a"},  32'(if_a.SC_DISPLAYSCAN_Segments_OutLow), 32'(v.seg_a[d]));
        chk({t, " seg_b"},  32'(if_b.SC_DISPLAYSCAN_Segments_OutLow), 32'(v.seg_b[d]));
        chk({t, " index"},  32'(if_a.SC_DISPLAYSCAN_DigitIndex_Out), 32'(d));
        chk({t, " update"}, 32'(if_a.SC_DISPLAYSCAN_Update_Out), 32'h0);
      end
      if (j == 14) bus = v.mid_bus;
    end
  endtask

  // Release reset at a negedge, then four BLANK cycles until the first LOAD.
  task automatic boot(input string tag);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_blank($sformatf("%s blank%0d", tag, k));
    end
  endtask

  initial begin
    // Segment tables are written digit 7 first, digit 0 last.
    vecs[0]  = mk(32'h000000A5, 1'b1, 32'h000000A5, 1'b1,
                  {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h12},
                  {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h12});
    vecs[1]  = mk(32'h00000000, 1'b1, 32'h00000000, 1'b1,
                  {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40},
                  {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40});
    vecs[2]  = mk(32'h12345678, 1'b1, 32'h87654321, 1'b1,
                  {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00},
                  {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00});
    vecs[3]  = mk(32'h87654321, 1'b1, 32'h87654321, 1'b1,
                  {7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79},
                  {7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79});
    vecs[4]  = mk(32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0,
                  {7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79},
                  {7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79});
    vecs[5]  = mk(32'h87654321, 1'b1, 32'h87654321, 1'b0,
                  {7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79},
                  {7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79});
    vecs[6]  = mk(32'h0000B0C0, 1'b1, 32'h0000B0C0, 1'b1,
                  {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h03, 7'h40, 7'h46, 7'h40},
                  {7'h40, 7'h40, 7'h40, 7'h40, 7'h03, 7'h40, 7'h46, 7'h40});
    vecs[7]  = mk(32'hFEDC9A00, 1'b1, 32'hFEDC9A00, 1'b1,
                  {7'h0E, 7'h06, 7'h21, 7'h46, 7'h10, 7'h08, 7'h40, 7'h40},
                  {7'h0E, 7'h06, 7'h21, 7'h46, 7'h10, 7'h08, 7'h40, 7'h40});
    vecs[8]  = mk(32'hFEDC9A00, 1'b1, 32'hFEDC9A00, 1'b0,
                  {7'h0E, 7'h06, 7'h21, 7'h46, 7'h10, 7'h08, 7'h40, 7'h40},
                  {7'h0E, 7'h06, 7'h21, 7'h46, 7'h10, 7'h08, 7'h40, 7'h40});
    // After reset the capture register is 0, so recapturing 0 is not a change.
    vecs[9]  = mk(32'h00000000, 1'b1, 32'h00000000, 1'b0,
                  {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40},
                  {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40});
    vecs[10] = vecs[0];

    // Held in reset: outputs stay at reset values while the clock runs.
    for (int k = 0; k < 3; k++) begin
      step();
      chk_blank($sformatf("reset%0d", k));
    end

    bus = 32'h000000A5;
    boot("boot");

    for (int i = 0; i < 8; i++) run_frame(i, vecs[i], 32);

    // Reset between clock edges while digit 5 is on.
    run_frame(8, vecs[8], 22);
    #1 rst_n = 1'b0;
    #1 chk_blank("async reset");
    for (int k = 0; k < 2; k++) begin
      step();
      chk_blank($sformatf("held reset%0d", k));
    end
    bus = 32'h0;
    boot("reboot");
    run_frame(9, vecs[9], 32);
    run_frame(10, vecs[10], 32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_display_scan.md
Name: sc_display_scan

Overview:
- Downstream consumer of the system's 32-bit display data bus (datapath + state machine top level).
- Captures the bus value once per scan frame, so a frame never mixes two values.
- Drives eight time-multiplexed, active-low, common-anode 7-segment hex digits, with optional leading-zero blanking.
- Reports whether the captured value changed.

Parameters:
- DATAWIDTH_BUS, 32, width of the display data bus (8 nibbles, one per digit; only 32 is supported).
- DATAWIDTH_PRESCALER, 16, width of the prescaler counter.
- PRESCALER_MAX, 49999, terminal count of the prescaler; digit period = PRESCALER_MAX+1 clocks (1 kHz at 50 MHz).
- LEADING_ZERO_BLANK, 1, 1 = blank leading zero digits; 0 = show all digits.

Ports:
- SC_DISPLAYSCAN_CLOCK_50  in  1  system clock.
- SC_DISPLAYSCAN_Reset_InLow  in  1  reset, asynchronous, active-low.
- SC_DISPLAYSCAN_DataBUS_In  in  DATAWIDTH_BUS  value to display.
- SC_DISPLAYSCAN_Freeze_InLow  in  1  0 = skip capture and hold the displayed value.
- SC_DISPLAYSCAN_Segments_OutLow  out  7  segments {g,f,e,d,c,b,a}, active-low.
- SC_DISPLAYSCAN_Anodes_OutLow  out  8  digit enables, one-hot active-low; bit i = nibble i (bit 0 = LSB nibble).
- SC_DISPLAYSCAN_DigitIndex_Out  out  3  digit currently scanned.
- SC_DISPLAYSCAN_Update_Out  out  1  one-cycle pulse when a newly captured value differs from the previous one.

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low: all state clears immediately when Reset_InLow goes low, independent of the clock.
- Reset values:
  - state = BLANK, prescaler = 0, index = 0, capture register = 0.
  - Anodes = 8'hFF, Segments = 7'h7F, DigitIndex = 0, Update = 0.
- Prescaler:
  - Counts 0..PRESCALER_MAX; tick = (count == PRESCALER_MAX); wraps to 0 on the same edge.
  - Runs in every state.
- FSM states BLANK, LOAD, SCAN:
  - BLANK: outputs stay at reset values. On tick -> LOAD.
  - LOAD (exactly one cycle): index <= 0. If Freeze_InLow = 1, capture <= DataBUS_In and a change flag is set if the new value differs from the old capture register; if Freeze_InLow = 0, no capture and the flag is 0. Then -> SCAN.
  - SCAN: on tick, index <= index+1. If index == 7 at the tick, index wraps to 0 and next state = LOAD.
- Outputs are registered, with one cycle of latency from state/index/capture to the pins:
  - Anodes = ~(1 << index) in SCAN; 8'hFF in BLANK and LOAD (one-cycle anti-ghost blank).
  - Segments = encode(capture[4*index+3 : 4*index]) in SCAN; 7'h7F otherwise.
  - DigitIndex = index.
  - Update = change flag, asserted on the first SCAN cycle after LOAD; 0 in every other cycle.
- Encoding (hex -> active-low gfedcba):
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78
  - 8 = 00, 9 = 10, A = 08, b = 03, C = 46, d = 21, E = 06, F = 0E
- Leading-zero blanking (LEADING_ZERO_BLANK = 1):
  - Digit i > 0 shows segments 7'h7F when capture nibbles 7..i are all zero; its anode is still driven.
  - Digit 0 is never blanked, so a value of 0 displays a single "0".
- Boundary conditions:
  - A bus change mid-frame has no effect until the next LOAD.
  - Freeze is sampled only in LOAD.
  - A tick coinciding with LOAD cannot occur (PRESCALER_MAX >= 1 is required). PRESCALER_MAX = 0 is illegal.
  - Reset asserted mid-scan returns to BLANK with reset outputs immediately.

Test Plan (PRESCALER_MAX = 3 for simulation):
- Hold reset low, toggle the clock -> Anodes = FF, Segments = 7F, DigitIndex = 0, Update = 0 throughout.
- Release reset with DataBUS = 0x000000A5:
  - The 4th clock is the tick -> LOAD, with Update = 1 for one cycle.
  - Digit 0: Anodes = FE, Segments = 12. Digit 1: Anodes = FD, Segments = 08.
  - Digits 2..7: Anodes walk FB..7F with Segments = 7F.
- DataBUS = 0x00000000 with blanking enabled -> digit 0 Segments = 40; digits 1..7 Segments = 7F. With LEADING_ZERO_BLANK = 0 -> all digits Segments = 40.
- DataBUS = 0x12345678, changed to 0x87654321 while digit 3 is shown:
  - The current frame finishes showing 8,7,6,5,4,3,2,1 (LSB first), i.e. Segments 00,78,02,12,19,30,24,79.
  - The next frame shows 0x87654321 and Update pulses once.
- Freeze_InLow = 0 across a LOAD while the bus changes -> the previous frame repeats and Update stays 0. Recapturing an identical value with Freeze_InLow = 1 -> Update stays 0.
- Assert reset asynchronously (between clock edges) while digit 5 is shown -> Anodes = FF and Segments = 7F before the next edge; after release the block restarts from BLANK.
